// File: rtl/alu_mul_if.sv
// alu_mul_if: EX-stage request/result bundle between the pipeline and the iterative multiplier
interface alu_mul_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic [4:0]       ALUCtl;
   logic             Sign;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             flush;
   logic             out_ready;
   logic             stall;
   logic             out_valid;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             busy;
   modport master (output in_valid, ALUCtl, Sign, in_a, in_b, flush, out_ready,
                   input stall, out_valid, result_lo, result_hi, busy);
   modport slave (input in_valid, ALUCtl, Sign, in_a, in_b, flush, out_ready,
                  output stall, out_valid, result_lo, result_hi, busy);
endinterface

// File: rtl/alu_mul_unit.sv
// alu_mul_unit: shift-add multiplier, one multiplier bit per cycle, signed via magnitudes
// MUL_EARLY_TERM_EN: leave BUSY as soon as the remaining multiplier bits are all zero
module alu_mul_unit #(
   parameter int         WIDTH    = 32,
   parameter logic [4:0] MUL_CODE = 5'b11010
) (
   input logic       clk,
   input logic       reset,
   alu_mul_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t             state, state_nxt;
   logic [2*WIDTH-1:0] acc, mcand, acc_nxt, prod;
   logic [WIDTH-1:0]   mplier, a_mag, b_mag;
   logic [CW-1:0]      count;
   logic               neg, accept, last;
   always_comb begin
      accept    = state == IDLE && bus.in_valid && bus.ALUCtl == MUL_CODE && !bus.flush;
      a_mag     = (bus.Sign && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
      b_mag     = (bus.Sign && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;
      acc_nxt   = acc + (mplier[0] ? mcand : '0);
      prod      = neg ? -acc_nxt : acc_nxt;
`ifdef MUL_EARLY_TERM_EN
      last      = count == CW'(WIDTH-1) || mplier[WIDTH-1:1] == '0;
`else
      last      = count == CW'(WIDTH-1);
`endif
      state_nxt = bus.flush ? IDLE :
                  accept ? BUSY :
                  (state == BUSY && last) ? DONE :
                  (state == DONE && bus.out_ready) ? IDLE : state;
      bus.stall     = (accept || state == BUSY) && !bus.flush;
      bus.out_valid = state == DONE;
      bus.busy      = state != IDLE;
   end
   always_ff @(posedge clk)
      state <= reset ? IDLE : state_nxt;
   always_ff @(posedge clk) begin
      if (reset) begin
         acc           <= '0;
         mcand         <= '0;
         mplier        <= '0;
         count         <= '0;
         neg           <= 1'b0;
         bus.result_lo <= '0;
         bus.result_hi <= '0;
      end else if (bus.flush) begin
         count <= '0;
      end else if (accept) begin
         acc    <= '0;
         count  <= '0;
         mcand  <= {{WIDTH{1'b0}}, a_mag};
         mplier <= b_mag;
         neg    <= bus.Sign && (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
      end else if (state == BUSY) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
         // the final step's sum is folded straight into the result registers
         if (last) {bus.result_hi, bus.result_lo} <= prod;
      end
   end
endmodule

// File: tb/tb_alu_mul_unit.sv
// tb_alu_mul_unit: random and directed MULs against an arithmetic product/latency model
module tb_alu_mul_unit;
   localparam int         W   = 32;
   localparam logic [4:0] MUL = 5'b11010;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   alu_mul_if #(.WIDTH(W)) bus ();
   alu_mul_unit #(.WIDTH(W), .MUL_CODE(MUL)) dut (.clk(clk), .reset(reset), .bus(bus));
   int checks = 0;
   int failures = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      return s ? 64'(sa * sb) : ua * ub;
   endfunction
   function automatic int exp_lat(input logic s, input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
      logic [31:0] m;
      int h;
      m = (s && b[31]) ? -b : b;
      h = 0;
      for (int i = 0; i < 32; i++) if (m[i]) h = i;
      return h + 2;
`else
      return W + 1;
`endif
   endfunction
   task automatic wait_valid(output int lat, output int stalls);
      lat = 1;
      stalls = 1;
      while (!bus.out_valid && lat < 100) begin
         stalls += int'(bus.stall);
         @(negedge clk);
         lat++;
      end
   endtask
   task automatic mul_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [63:0] e;
      int lat, stalls;
      e = model(s, a, b);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.ALUCtl = MUL;
      bus.Sign = s;
      bus.in_a = a;
      bus.in_b = b;
      #1 check("accept_stall", bus.stall, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_valid(lat, stalls);
      check("latency", lat, exp_lat(s, b));
      check("stall_cycles", stalls, exp_lat(s, b));
      check("done_stall", bus.stall, 0);
      check("lo", bus.result_lo, e[31:0]);
      check("hi", bus.result_hi, e[63:32]);
      repeat (hold) begin
         @(negedge clk);
         check("hold_valid", bus.out_valid, 1);
         check("hold_stall", bus.stall, 0);
         check("hold_prod", {bus.result_hi, bus.result_lo}, e);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("handoff_valid", bus.out_valid, 0);
      check("handoff_busy", bus.busy, 0);
      check("held_prod", {bus.result_hi, bus.result_lo}, e);
   endtask
   task automatic start_long();
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.ALUCtl = MUL;
      bus.Sign = 1'b0;
      bus.in_a = 32'd9;
      bus.in_b = 32'hFFFF_FFFF;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   initial begin
      int lat, stalls, seen;
      bus.in_valid = 1'b0;
      bus.ALUCtl = '0;
      bus.Sign = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_stall", bus.stall, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_result", {bus.result_hi, bus.result_lo}, 0);
      reset = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.ALUCtl = 5'b00010;
      #1 check("other_stall", bus.stall, 0);
      @(negedge clk);
      check("other_busy", bus.busy, 0);
      bus.in_valid = 1'b0;
      mul_op(1'b0, 32'hFFFF_FFFF, 32'h2, 0);
      mul_op(1'b1, 32'hFFFF_FFF9, 32'd6, 0);
      mul_op(1'b0, 32'hFFFF_FFF9, 32'd6, 0);
      mul_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
      mul_op(1'b1, 32'h8000_0000, 32'd1, 0);
      mul_op(1'b0, 32'd3, 32'd5, 5);
      mul_op(1'b0, 32'd3, 32'd0, 0);
      mul_op(1'b1, 32'd12345, 32'hFFFF_FF00, 2);
      // flush in BUSY cycle 10 must kill the op without ever raising out_valid
      start_long();
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      #1 check("flush_stall", bus.stall, 0);
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_busy", bus.busy, 0);
      seen = 0;
      repeat (40) begin
         seen += int'(bus.out_valid);
         @(negedge clk);
      end
      check("flush_no_valid", seen, 0);
      start_long();
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_valid", bus.out_valid, 0);
      check("rst_mid_result", {bus.result_hi, bus.result_lo}, 0);
      mul_op(1'b0, 32'd3, 32'd5, 0);
      // a MUL presented during handoff waits for the following IDLE cycle
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a = 32'd2;
      bus.in_b = 32'd7;
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_valid(lat, stalls);
      check("b2b_first_lo", bus.result_lo, 14);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_a = 32'd4;
      bus.in_b = 32'd4;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("b2b_not_taken", bus.busy, 0);
      check("b2b_idle_stall", bus.stall, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("b2b_taken", bus.busy, 1);
      wait_valid(lat, stalls);
      check("b2b_second_lo", bus.result_lo, 16);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 20; i++)
         mul_op(1'($urandom_range(0, 1)), $urandom,
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom,
                $urandom_range(0, 2));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_mul_unit.md
Name: alu_mul_unit

Overview:
Multi-cycle iterative multiplier on the ALU control interface. It sits in EX beside the single-cycle ALU and accepts an operation only when the decoded 5-bit ALU control code equals MUL (5'b11010). It honours the signed/unsigned flag from the same decoder and returns a 64-bit product. While it works it asserts a stall toward the hazard unit, and it holds the result until the pipeline takes it.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits wide.
MUL_CODE, 5'b11010, ALU control value that selects this unit.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  the EX-stage instruction is valid this cycle
ALUCtl  input  5  decoded ALU operation code
Sign  input  1  1 = operands are two's complement, 0 = unsigned
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
flush  input  1  abort any in-flight operation
out_ready  input  1  pipeline consumes the result this cycle
stall  output  1  hold the IF/ID/EX stages
out_valid  output  1  result_lo and result_hi are valid
result_lo  output  WIDTH  product bits [WIDTH-1:0]
result_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
busy  output  1  unit is not in IDLE

Behaviour:
- Reset: the active-high reset is synchronous. On reset: state=IDLE, stall=0, out_valid=0, result_lo=0, result_hi=0, busy=0, count=0.
- States: IDLE, BUSY, DONE.
- Accept (IDLE): when in_valid=1 and ALUCtl==MUL_CODE, capture the operands.
  - If Sign=1, capture |in_a| and |in_b| and set neg = in_a[MSB]^in_b[MSB].
  - If Sign=0, capture the raw operands and set neg=0.
  - Clear the 2*WIDTH accumulator and count, then go to BUSY.
  - stall is combinationally 1 in the accept cycle.
- Any other ALUCtl while in IDLE: ignored, no stall, no state change.
- BUSY, each cycle:
  - If mplier[0]=1, acc += mcand (2*WIDTH wide, zero-extended).
  - Shift mcand left by 1 and mplier right by 1; count++.
  - Go to DONE after the cycle with count==WIDTH-1, i.e. exactly WIDTH BUSY cycles.
- Entering DONE: load result = neg ? -acc : acc (2*WIDTH two's complement) and split it into hi and lo.
  - Magnitude edge case: -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2), which fits.
  - Magnitude edge case: -2^(WIDTH-1) * 1 negates correctly through unsigned magnitudes.
- DONE: out_valid=1 and stall=0.
  - If out_ready=1, go to IDLE next cycle; out_valid drops and the result registers hold their value.
  - If out_ready=0, stay in DONE with the result held stable.
- stall is 1 for the accept cycle plus all BUSY cycles, and 0 in DONE and IDLE. Latency from accept to out_valid is WIDTH+1 cycles (33 by default).
- A new MUL is accepted only from IDLE. The cycle after DONE hands off is IDLE, so back-to-back MULs have one IDLE cycle between them.
- flush in any state: go to IDLE next cycle; out_valid=0, stall=0, count=0.
  - flush has priority over accept and over out_ready.
  - A MUL presented in the same cycle as flush is not accepted.
- reset mid-operation: identical to the reset values above; the partial product is discarded.
- Simultaneous out_ready and a new MUL while in DONE: the handoff completes and the new MUL is not accepted. The upstream stage keeps presenting it, and it is accepted on the following IDLE cycle.
- busy = (state != IDLE).

Optional Feature:
Macro: MUL_EARLY_TERM_EN.
- Defined: BUSY also exits to DONE when the post-shift multiplier value is zero. Latency becomes (index of the highest set bit of |in_b|)+2 cycles, and a zero multiplier gives 2 cycles (one BUSY cycle). stall follows the shorter BUSY period. Results are identical to the fixed-latency mode.
- Undefined: fixed WIDTH BUSY cycles, and the early-exit comparator is absent.

Test Plan:
- Unsigned: Sign=0, in_a=32'hFFFF_FFFF, in_b=32'h0000_0002 → after 33 cycles hi=32'h1, lo=32'hFFFF_FFFE; stall high for exactly 33 cycles.
- Signed: Sign=1, in_a=-7 (32'hFFFF_FFF9), in_b=6 → hi=32'hFFFF_FFFF, lo=32'hFFFF_FFD6 (-42). Same operands with Sign=0 → hi=32'h5, lo=32'hFFFF_FFD6.
- Corner: Sign=1, in_a=in_b=32'h8000_0000 → hi=32'h4000_0000, lo=0. ALUCtl=5'b00010 with in_valid=1 → no stall and busy stays 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and the result stay stable with stall=0. Then pulse out_ready for one cycle → IDLE next cycle.
- Abort: assert flush in BUSY cycle 10, then assert reset in BUSY cycle 5 of a later operation → IDLE next cycle, out_valid never asserted, and a fresh 3*5 afterwards returns lo=15.
- With MUL_EARLY_TERM_EN defined: in_b=5 → out_valid 4 cycles after accept, lo=15; in_b=0 → out_valid 2 cycles after accept, result 0.
